serial_key_link_ctrl: RTL and testbench

- Shares one serial key-code link between N_REQ key sources (round-robin) and sequences each frame onto the line.
- Frame on the line: start bit 0, then 4 code bits LSB first, then GAP_CYCLES idle-high cycles.
- Also drives the link's reset line to abort a frame in flight.
- Sits between the key scanners and the serial key-protocol receiver; both run on the same clk.

---
 rtl/key_link_pkg.sv | 20 ++
 rtl/serial_key_link_ctrl_rr_arbiter.sv | 52 +++++
 rtl/serial_key_link_ctrl.sv | 176 +++++++++++++++++
 tb/tb_serial_key_link_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_link_pkg.sv
// Shared types and constants for the serial key-code link controller.
// Holds the frame FSM state enum, line levels and the standard key codes.
package key_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        GAP,
        ABORT
    } state_e;

    localparam int         CODE_W      = 4;
    localparam logic       START_LEVEL = 1'b0;
    localparam logic       IDLE_LEVEL  = 1'b1;

    localparam logic [3:0] KEY_SET = 4'b1001;
    localparam logic [3:0] KEY_CLR = 4'b1010;

endpackage

// File: rtl/serial_key_link_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks one requester starting from the pointer.
// Ports: clk, rst, req[N_REQ], advance in; grant_oh[N_REQ], grant_idx out.
module rr_arbiter #(
    parameter int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] idx_w;
    logic             found;

    // Scan from the pointer upward, wrapping; first set request wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_w     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx_w = IDX_W'((int'(ptr_q) + off) % N_REQ);
            if (!found && req[idx_w]) begin
                found           = 1'b1;
                grant_oh[idx_w] = 1'b1;
                grant_idx       = idx_w;
            end
        end
    end

    // The source after the winner gets top priority next time.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = IDX_W'((int'(grant_idx) + 1) % N_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/serial_key_link_ctrl.sv
// Shares one serial key-code link among N_REQ sources and frames codes.
// Ports: clk, rst, req, code, abort in; grant, busy, ser_data, link_rst, done, aborted out.
module serial_key_link_ctrl
    import key_link_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = 1,
    parameter int ABORT_HOLD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [CODE_W*N_REQ-1:0] code,
    input  logic                    abort,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    ser_data,
    output logic                    link_rst,
    output logic                    done,
    output logic                    aborted
);

    localparam int IDX_W    = $clog2(N_REQ);
    localparam int GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int HOLD_EFF = (ABORT_HOLD < 2) ? 2 : ABORT_HOLD;
    localparam int CNT_MAX  = (GAP_EFF > HOLD_EFF) ? GAP_EFF : HOLD_EFF;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_EFF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);

    state_e              state_q, state_d;
    logic [1:0]          bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                ser_q, ser_d;
    logic                link_rst_q, link_rst_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic                advance;
    logic [N_REQ-1:0]    grant_oh;
    logic [IDX_W-1:0]    grant_idx;
    logic [CODE_W-1:0]   win_code;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (advance),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx)
    );

    assign win_code = code[{grant_idx, 2'b00} +: CODE_W];

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        grant_d   = '0;
        advance   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = START;
                    advance = 1'b1;
                    code_d  = win_code;
                    grant_d = grant_oh;
                end
            end
            START: begin
                if (abort) begin
                    state_d = ABORT;
                    cnt_d   = '0;
                end else begin
                    state_d   = BIT;
                    bit_cnt_d = 2'd0;
                end
            end
            BIT: begin
                // Abort wins over the last-bit transition.
                if (abort) begin
                    state_d = ABORT;
                    cnt_d   = '0;
                end else if (bit_cnt_q == 2'd3) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 2'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (|req) begin
                        state_d = START;
                        advance = 1'b1;
                        code_d  = win_code;
                        grant_d = grant_oh;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ABORT: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave flops.
    always_comb begin
        ser_d      = IDLE_LEVEL;
        busy_d     = (state_d != IDLE);
        done_d     = 1'b0;
        link_rst_d = 1'b0;
        aborted_d  = 1'b0;
        unique case (state_d)
            START: ser_d = START_LEVEL;
            BIT:   ser_d = code_d[bit_cnt_d];
            GAP:   done_d = (cnt_d == GAP_LAST);
            ABORT: begin
                link_rst_d = (state_q != ABORT);
                aborted_d  = (state_q != ABORT);
            end
            default: ser_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 2'd0;
            cnt_q      <= '0;
            code_q     <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            ser_q      <= IDLE_LEVEL;
            link_rst_q <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            ser_q      <= ser_d;
            link_rst_q <= link_rst_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign ser_data = ser_q;
    assign link_rst = link_rst_q;
    assign done     = done_q;
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_serial_key_link_ctrl.sv
// Bench for serial_key_link_ctrl: two instances (gap 1 and gap 3).
// A frame-position reference model feeds per-cycle expectations to a scoreboard.
module tb_serial_key_link_ctrl;
    import key_link_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [2];
    logic [1:0] req_s   [2];
    logic [7:0] code_s  [2];
    logic       abort_s [2];
    logic       drop_s  [2];

    logic [1:0] grant_w [2];
    logic       busy_w  [2];
    logic       ser_w   [2];
    logic       lrst_w  [2];
    logic       done_w  [2];
    logic       abrt_w  [2];

    serial_key_link_ctrl #(.N_REQ(2), .GAP_CYCLES(1), .ABORT_HOLD(2)) dut0 (
        .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .code(code_s[0]),
        .abort(abort_s[0]), .grant(grant_w[0]), .busy(busy_w[0]),
        .ser_data(ser_w[0]), .link_rst(lrst_w[0]), .done(done_w[0]),
        .aborted(abrt_w[0])
    );

    serial_key_link_ctrl #(.N_REQ(2), .GAP_CYCLES(3), .ABORT_HOLD(2)) dut1 (
        .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .code(code_s[1]),
        .abort(abort_s[1]), .grant(grant_w[1]), .busy(busy_w[1]),
        .ser_data(ser_w[1]), .link_rst(lrst_w[1]), .done(done_w[1]),
        .aborted(abrt_w[1])
    );

    // Expected observation: {grant[1:0], busy, ser, link_rst, done, aborted}
    logic [6:0] exp_q [2][$];
    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 framing (position on the line), 2 abort hold.
    int         m_phase [2];
    int         m_pos   [2];
    int         m_hold  [2];
    int         m_last  [2];
    int         m_src   [2];
    logic [3:0] m_code  [2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_phase[u] = 0; m_pos[u] = 0; m_hold[u] = 0;
            m_last[u] = 1; m_src[u] = 0; m_code[u] = 4'h0;
        end
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int gap;
            logic do_pick;
            logic [6:0] e;
            gap = (u == 0) ? 1 : 3;
            do_pick = 1'b0;
            if (rst_s[u]) begin
                m_phase[u] = 0;
                m_last[u]  = 1;
            end else if (m_phase[u] == 0) begin
                do_pick = (req_s[u] != 2'b00);
            end else if (m_phase[u] == 1) begin
                if (m_pos[u] <= 4 && abort_s[u]) begin
                    m_phase[u] = 2;
                    m_hold[u]  = 0;
                end else if (m_pos[u] == 4 + gap) begin
                    if (req_s[u] != 2'b00) do_pick = 1'b1;
                    else m_phase[u] = 0;
                end else begin
                    m_pos[u]++;
                end
            end else begin
                if (m_hold[u] == 1) m_phase[u] = 0;
                else m_hold[u]++;
            end
            if (do_pick) begin
                // Priority starts just after the last source granted.
                for (int off = 1; off <= 2; off++) begin
                    int i;
                    i = (m_last[u] + off) % 2;
                    if (do_pick && req_s[u][i]) begin
                        do_pick    = 1'b0;
                        m_src[u]   = i;
                        m_last[u]  = i;
                        m_code[u]  = code_s[u][4*i +: 4];
                        m_phase[u] = 1;
                        m_pos[u]   = 0;
                    end
                end
            end
            e = 7'b00_0_1_0_0_0;
            if (m_phase[u] == 1) begin
                e[4] = 1'b1;
                if (m_pos[u] == 0) begin
                    e[6:5] = 2'b01 << m_src[u];
                    e[3]   = 1'b0;
                end else if (m_pos[u] <= 4) begin
                    e[3] = m_code[u][m_pos[u] - 1];
                end
                e[1] = (m_pos[u] == 4 + gap);
            end else if (m_phase[u] == 2) begin
                e[4] = 1'b1;
                e[2] = (m_hold[u] == 0);
                e[0] = (m_hold[u] == 0);
            end
            exp_q[u].push_back(e);
        end
    end

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic [6:0] a;
            logic [6:0] e;
            if (exp_q[u].size() > 0) begin
                e = exp_q[u].pop_front();
                a = {grant_w[u], busy_w[u], ser_w[u], lrst_w[u],
                     done_w[u], abrt_w[u]};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL dut%0d t=%0t {grant,busy,ser,lrst,done,abrt} got=%b exp=%b",
                             u, $time, a, e);
                end
            end
        end
    end

    task automatic step(input int u);
        @(negedge clk);
        if (drop_s[u]) req_s[u] = req_s[u] & ~grant_w[u];
    endtask

    task automatic steps(input int u, input int n);
        for (int k = 0; k < n; k++) step(u);
    endtask

    task automatic do_reset(input int u);
        rst_s[u] = 1'b1;
        req_s[u] = 2'b00;
        abort_s[u] = 1'b0;
        steps(u, 2);
        rst_s[u] = 1'b0;
        step(u);
    endtask

    task automatic run_seq(input int u);
        rst_s[u] = 1'b1; req_s[u] = 2'b00; code_s[u] = 8'h00;
        abort_s[u] = 1'b0; drop_s[u] = 1'b1;
        do_reset(u);
        // Single frame, KEY_SET from source 0.
        code_s[u][3:0] = KEY_SET;
        req_s[u] = 2'b01;
        steps(u, 12);
        // Both sources at once, back-to-back, then source 0 wins again.
        do_reset(u);
        code_s[u] = {KEY_CLR, KEY_SET};
        req_s[u] = 2'b11;
        steps(u, 20);
        req_s[u] = 2'b11;
        steps(u, 20);
        // Source 0 held continuously.
        drop_s[u] = 1'b0;
        code_s[u][3:0] = KEY_CLR;
        req_s[u] = 2'b01;
        steps(u, 24);
        req_s[u] = 2'b00;
        drop_s[u] = 1'b1;
        steps(u, 10);
        // Abort during the second bit with source 1 waiting.
        code_s[u] = {KEY_CLR, KEY_SET};
        req_s[u] = 2'b01;
        steps(u, 3);
        abort_s[u] = 1'b1;
        req_s[u] = req_s[u] | 2'b10;
        step(u);
        abort_s[u] = 1'b0;
        steps(u, 14);
        // Reset during the third bit, then source 1.
        req_s[u] = 2'b01;
        steps(u, 4);
        rst_s[u] = 1'b1;
        step(u);
        rst_s[u] = 1'b0;
        req_s[u] = 2'b10;
        steps(u, 14);
        // Abort landing in the gap is ignored.
        req_s[u] = 2'b01;
        steps(u, 6);
        abort_s[u] = 1'b1;
        step(u);
        abort_s[u] = 1'b0;
        steps(u, 10);
        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            rst_s[u]   = ($urandom_range(99) == 0);
            abort_s[u] = ($urandom_range(19) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!req_s[u][i] && $urandom_range(3) == 0) begin
                    code_s[u][4*i +: 4] = 4'($urandom);
                    req_s[u][i] = 1'b1;
                end
            end
            step(u);
        end
        rst_s[u] = 1'b0; abort_s[u] = 1'b0; req_s[u] = 2'b00;
        steps(u, 12);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; req_s[u] = 2'b00; code_s[u] = 8'h00;
            abort_s[u] = 1'b0; drop_s[u] = 1'b1;
        end
        fork
            run_seq(0);
            run_seq(1);
        join
        repeat (2) @(negedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (exp_q[u].size() != 0) begin
                errors++;
                $display("FAIL dut%0d drain pending=%0d exp=0", u, exp_q[u].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
